// File: rtl/lock_pkg.sv
// Shared definitions for the door-lock supervisor: the 3-bit lock state
// encoding consumed by the display and keypad blocks.
package lock_pkg;

   typedef enum logic [2:0] {
      ST_OFF        = 3'b000,
      ST_ON         = 3'b001,
      ST_WRONG      = 3'b010,
      ST_WRONG_LAST = 3'b011,
      ST_ANSWER     = 3'b100,
      ST_RESET      = 3'b101,
      ST_LOCK       = 3'b111
   } lock_state_t;

endpackage

// File: rtl/edge_sync_rise.sv
// Two-flop synchroniser followed by a rising-edge detector.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : raw level, asynchronous to clk
//   rise_c     : one-cycle pulse on a synchronised 0->1 transition (combinational)
module edge_sync_rise (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise_c
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Synchroniser chain plus one delayed copy for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= din;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rise_c = sync_q & ~prev_q;

endmodule

// File: rtl/lock_state_manager_p.sv
// Parametrised door-lock supervisor. Evaluates keypad/button controls once per
// divided tick and drives the 3-bit lock state.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   is_on           : power level (1 = on)
//   is_star_pressed : raw '*' key level, asynchronous to clk
//   pw_reset        : password-change request level
//   correct         : entered code matches (in RESET: new code length valid)
//   initialize      : factory-initialise level
//   state           : current lock state (registered)
//   wrong_cnt       : consecutive wrong attempts (registered, saturating)
//   sample_tick     : one-cycle pulse per evaluation tick (registered)
module lock_state_manager_p
   import lock_pkg::*;
#(
   parameter  int unsigned SAMPLE_DIV         = 50000,
   parameter  int unsigned MAX_WRONG          = 3,
   parameter  int unsigned LOCKOUT_TICKS      = 0,
   parameter  int unsigned OPEN_TIMEOUT_TICKS = 0,
   localparam int unsigned CW                 = $clog2(MAX_WRONG + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          is_on,
   input  logic          is_star_pressed,
   input  logic          pw_reset,
   input  logic          correct,
   input  logic          initialize,
   output logic [2:0]    state,
   output logic [CW-1:0] wrong_cnt,
   output logic          sample_tick
);

   localparam int unsigned DW  = $clog2(SAMPLE_DIV);
   localparam int unsigned LTW = (LOCKOUT_TICKS < 1) ? 1 : $clog2(LOCKOUT_TICKS + 1);
   localparam int unsigned OTW = (OPEN_TIMEOUT_TICKS < 1) ? 1 : $clog2(OPEN_TIMEOUT_TICKS + 1);

   logic [DW-1:0]  div_q;
   logic           tick_q;
   logic           star_rise_c;
   logic           star_pend_q;

   lock_state_t    state_q,    state_d;
   logic [CW-1:0]  cnt_q,      cnt_d;
   logic [LTW-1:0] lock_tmr_q, lock_tmr_d;
   logic [OTW-1:0] open_tmr_q, open_tmr_d;
   logic [CW-1:0]  cnt_inc;

   // Tick divider; the tick flop is loaded one count early so it is high
   // exactly while the divider sits at SAMPLE_DIV-1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         div_q  <= (div_q == DW'(SAMPLE_DIV - 1)) ? '0 : div_q + DW'(1);
         tick_q <= (div_q == DW'(SAMPLE_DIV - 2));
      end
   end

   edge_sync_rise u_star_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (is_star_pressed),
      .rise_c (star_rise_c)
   );

   // Pending star: cleared every tick; a new edge in a tick cycle wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         star_pend_q <= 1'b0;
      end else if (star_rise_c) begin
         star_pend_q <= 1'b1;
      end else if (tick_q) begin
         star_pend_q <= 1'b0;
      end
   end

   // State, penalty count and timers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_OFF;
         cnt_q      <= '0;
         lock_tmr_q <= '0;
         open_tmr_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lock_tmr_q <= lock_tmr_d;
         open_tmr_q <= open_tmr_d;
      end
   end

   assign cnt_inc = (cnt_q == CW'(MAX_WRONG)) ? cnt_q : cnt_q + CW'(1);

   // Next-state evaluation, active only in tick cycles
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lock_tmr_d = lock_tmr_q;
      open_tmr_d = open_tmr_q;

      if (tick_q) begin
         if (initialize) begin
            state_d    = ST_OFF;
            cnt_d      = '0;
            lock_tmr_d = '0;
            open_tmr_d = '0;
         end else if (state_q == ST_LOCK) begin
            if (LOCKOUT_TICKS > 0) begin
               lock_tmr_d = lock_tmr_q + LTW'(1);
               if (lock_tmr_d == LTW'(LOCKOUT_TICKS)) begin
                  lock_tmr_d = '0;
                  cnt_d      = '0;
                  state_d    = is_on ? ST_ON : ST_OFF;
               end
            end
         end else if (!is_on) begin
            state_d = ST_OFF;
         end else begin
            case (state_q)
               ST_OFF: begin
                  if (cnt_q == '0)                           state_d = ST_ON;
                  else if (cnt_q == CW'(MAX_WRONG - 1))      state_d = ST_WRONG_LAST;
                  else                                       state_d = ST_WRONG;
               end
               ST_ON, ST_WRONG, ST_WRONG_LAST: begin
                  if (star_pend_q) begin
                     if (correct) begin
                        state_d    = ST_ANSWER;
                        cnt_d      = '0;
                        open_tmr_d = '0;
                     end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CW'(MAX_WRONG)) begin
                           state_d    = ST_LOCK;
                           lock_tmr_d = '0;
                        end else if (cnt_inc == CW'(MAX_WRONG - 1)) begin
                           state_d = ST_WRONG_LAST;
                        end else begin
                           state_d = ST_WRONG;
                        end
                     end
                  end
               end
               ST_ANSWER: begin
                  if (pw_reset) begin
                     state_d = ST_RESET;
                  end else if (OPEN_TIMEOUT_TICKS > 0) begin
                     open_tmr_d = open_tmr_q + OTW'(1);
                     if (open_tmr_d == OTW'(OPEN_TIMEOUT_TICKS)) begin
                        open_tmr_d = '0;
                        state_d    = ST_ON;
                     end
                  end
               end
               ST_RESET: begin
                  if (star_pend_q && correct) state_d = ST_ON;
               end
               default: state_d = ST_OFF;
            endcase
         end
      end
   end

   assign state       = state_q;
   assign wrong_cnt   = cnt_q;
   assign sample_tick = tick_q;

endmodule
